// File: rtl/updi_pkg.sv
// Shared UPDI types: instruction modes, frame constants, bridge state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package updi_pkg;

    typedef enum logic [2:0] {
        MODE_IDLE = 3'd0,
        MODE_LDCS = 3'd1,
        MODE_STCS = 3'd2,
        MODE_LDS  = 3'd3,
        MODE_STS  = 3'd4,
        MODE_KEY  = 3'd5
    } updi_bridge_mode;

    localparam logic [7:0] UPDI_SYNCH        = 8'h55;
    localparam logic [7:0] UPDI_ACK          = 8'h40;
    localparam logic [7:0] UPDI_OP_LDCS      = 8'h80;
    localparam logic [7:0] UPDI_OP_STCS      = 8'hC0;
    localparam logic [7:0] UPDI_OP_LDS_A16_B = 8'h04;
    localparam logic [7:0] UPDI_OP_STS_A16_B = 8'h44;
    localparam logic [7:0] UPDI_OP_KEY_64    = 8'hE0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_ECHO,
        ST_RECV,
        ST_DONE
    } bridge_state_t;

endpackage

// File: rtl/updi_frame_byte_sel.sv
// Maps (mode, byte index, latched operands) to the UPDI frame byte, frame length and response point.
// Latency: purely combinational.
// Backpressure: none; the bridge owns all sequencing.
// Ports: mode/idx/cs_addr/addr/data/key in; tx_byte (byte at idx), frame_len (TX bytes in frame),
//        rsp_after (a target response follows the byte at idx) out.
module updi_frame_byte_sel
    import updi_pkg::*;
(
    input  updi_bridge_mode mode,
    input  logic [3:0]      idx,
    input  logic [3:0]      cs_addr,
    input  logic [15:0]     addr,
    input  logic [7:0]      data,
    input  logic [63:0]     key,
    output logic [7:0]      tx_byte,
    output logic [3:0]      frame_len,
    output logic            rsp_after
);

    // Key bytes occupy frame indices 2..9; the low 3 bits wrap cleanly onto key byte 0..7.
    logic [2:0] key_sel;
    assign key_sel = idx[2:0] - 3'd2;

    always_comb begin
        tx_byte   = UPDI_SYNCH;
        frame_len = 4'd0;
        rsp_after = 1'b0;
        case (mode)
            MODE_LDCS: begin
                frame_len = 4'd2;
                rsp_after = (idx == 4'd1);
                if (idx == 4'd1) tx_byte = UPDI_OP_LDCS | {4'h0, cs_addr};
            end
            MODE_STCS: begin
                frame_len = 4'd3;
                if (idx == 4'd1) tx_byte = UPDI_OP_STCS | {4'h0, cs_addr};
                if (idx == 4'd2) tx_byte = data;
            end
            MODE_LDS: begin
                frame_len = 4'd4;
                rsp_after = (idx == 4'd3);
                if (idx == 4'd1) tx_byte = UPDI_OP_LDS_A16_B;
                if (idx == 4'd2) tx_byte = addr[7:0];
                if (idx == 4'd3) tx_byte = addr[15:8];
            end
            MODE_STS: begin
                // ACK after the address and again after the data byte.
                frame_len = 4'd5;
                rsp_after = (idx == 4'd3) || (idx == 4'd4);
                if (idx == 4'd1) tx_byte = UPDI_OP_STS_A16_B;
                if (idx == 4'd2) tx_byte = addr[7:0];
                if (idx == 4'd3) tx_byte = addr[15:8];
                if (idx == 4'd4) tx_byte = data;
            end
            MODE_KEY: begin
                frame_len = 4'd10;
                if (idx == 4'd1)      tx_byte = UPDI_OP_KEY_64;
                else if (idx != 4'd0) tx_byte = key[{key_sel, 3'b000} +: 8];
            end
            default: begin
                frame_len = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/updi_bridge.sv
// Serialises one UPDI instruction into frame bytes, checks the single-wire echo, collects the response.
// Latency: one response per instruction; IDLE mode answers the cycle after the handshake.
// Backpressure: cmd_ready only in IDLE; tx_valid holds byte until tx_ready; RX waits bounded by TIMEOUT_CYCLES.
// Ports: cmd_* request in, rsp_* one-cycle result out, tx_* UART TX valid/ready, rx_* UART RX strobe.
module updi_bridge
    import updi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  updi_bridge_mode cmd_mode,
    input  logic [3:0]      cmd_cs_addr,
    input  logic [15:0]     cmd_addr,
    input  logic [7:0]      cmd_data,
    input  logic [63:0]     cmd_key,
    output logic            rsp_valid,
    output logic [7:0]      rsp_data,
    output logic            rsp_error,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic [7:0]      tx_data,
    input  logic            rx_valid,
    input  logic [7:0]      rx_data,
    input  logic            rx_frame_err
);

    localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    bridge_state_t   state, state_n;
    logic [3:0]      idx, idx_n;
    logic [CW-1:0]   tmo_cnt, tmo_cnt_n;
    logic            err, err_n;
    logic [7:0]      rsp_data_q, rsp_data_n;

    updi_bridge_mode mode_q;
    logic [3:0]      cs_q;
    logic [15:0]     addr_q;
    logic [7:0]      data_q;
    logic [63:0]     key_q;

    logic [7:0]      sel_byte;
    logic [3:0]      frame_len;
    logic            rsp_after;
    logic            cmd_fire;

    updi_frame_byte_sel u_sel (
        .mode      (mode_q),
        .idx       (idx),
        .cs_addr   (cs_q),
        .addr      (addr_q),
        .data      (data_q),
        .key       (key_q),
        .tx_byte   (sel_byte),
        .frame_len (frame_len),
        .rsp_after (rsp_after)
    );

    assign cmd_ready = (state == ST_IDLE) && !rst;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign tx_valid  = (state == ST_SEND);
    assign tx_data   = tx_valid ? sel_byte : 8'h00;
    assign rsp_valid = (state == ST_DONE);
    assign rsp_error = rsp_valid && err;
    assign rsp_data  = rsp_data_q;

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        tmo_cnt_n  = tmo_cnt;
        err_n      = err;
        rsp_data_n = rsp_data_q;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    idx_n = 4'd0;
                    err_n = 1'b0;
                    if (cmd_mode == MODE_IDLE) begin
                        rsp_data_n = 8'h00;
                        state_n    = ST_DONE;
                    end else begin
                        state_n = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                // rx_valid is not looked at here: an echo cannot precede its byte.
                if (tx_ready) begin
                    tmo_cnt_n = '0;
                    state_n   = ST_ECHO;
                end
            end
            ST_ECHO: begin
                if (rx_valid) begin
                    if (rx_frame_err || (rx_data != sel_byte)) begin
                        err_n      = 1'b1;
                        rsp_data_n = 8'h00;
                        state_n    = ST_DONE;
                    end else begin
                        idx_n = idx + 4'd1;
                        if (rsp_after) begin
                            tmo_cnt_n = '0;
                            state_n   = ST_RECV;
                        end else if (idx == frame_len - 4'd1) begin
                            rsp_data_n = 8'h00;
                            state_n    = ST_DONE;
                        end else begin
                            state_n = ST_SEND;
                        end
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    err_n      = 1'b1;
                    rsp_data_n = 8'h00;
                    state_n    = ST_DONE;
                end else begin
                    tmo_cnt_n = tmo_cnt + CW'(1);
                end
            end
            ST_RECV: begin
                if (rx_valid) begin
                    if (rx_frame_err) begin
                        err_n      = 1'b1;
                        rsp_data_n = 8'h00;
                        state_n    = ST_DONE;
                    end else if (mode_q == MODE_STS) begin
                        rsp_data_n = 8'h00;
                        if (rx_data != UPDI_ACK) begin
                            err_n   = 1'b1;
                            state_n = ST_DONE;
                        end else if (idx < frame_len) begin
                            // First ACK: the data byte still has to go out.
                            state_n = ST_SEND;
                        end else begin
                            state_n = ST_DONE;
                        end
                    end else begin
                        rsp_data_n = rx_data;
                        state_n    = ST_DONE;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    err_n      = 1'b1;
                    rsp_data_n = 8'h00;
                    state_n    = ST_DONE;
                end else begin
                    tmo_cnt_n = tmo_cnt + CW'(1);
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= 4'd0;
            tmo_cnt    <= '0;
            err        <= 1'b0;
            rsp_data_q <= 8'h00;
            mode_q     <= MODE_IDLE;
            cs_q       <= 4'h0;
            addr_q     <= 16'h0000;
            data_q     <= 8'h00;
            key_q      <= 64'h0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            tmo_cnt    <= tmo_cnt_n;
            err        <= err_n;
            rsp_data_q <= rsp_data_n;
            if (cmd_fire) begin
                mode_q <= cmd_mode;
                cs_q   <= cmd_cs_addr;
                addr_q <= cmd_addr;
                data_q <= cmd_data;
                key_q  <= cmd_key;
            end
        end
    end

endmodule

// File: tb/tb_updi_bridge.sv
// Bench for updi_bridge: acts as programmer, UART and target; frames come from an independent model.
// Latency: checks timeout distance of 16 cycles and single-cycle rsp_valid pulses.
// Backpressure: exercises tx_ready stalls, stray RX strobes, errors and mid-frame reset.
module tb_updi_bridge;
    import updi_pkg::*;

    logic            clk;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    updi_bridge_mode cmd_mode;
    logic [3:0]      cmd_cs_addr;
    logic [15:0]     cmd_addr;
    logic [7:0]      cmd_data;
    logic [63:0]     cmd_key;
    logic            rsp_valid;
    logic [7:0]      rsp_data;
    logic            rsp_error;
    logic            tx_valid;
    logic            tx_ready;
    logic [7:0]      tx_data;
    logic            rx_valid;
    logic [7:0]      rx_data;
    logic            rx_frame_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_tx[$];
    int         rsp_pts[$];

    updi_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_mode     (cmd_mode),
        .cmd_cs_addr  (cmd_cs_addr),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .cmd_key      (cmd_key),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_error    (rsp_error),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_frame_err (rx_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: run did not finish, observed hang expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: TX byte list and the byte counts after which the target answers.
    task automatic build(input updi_bridge_mode m, input logic [3:0] cs, input logic [15:0] addr,
                         input logic [7:0] data, input logic [63:0] key);
        exp_tx  = {};
        rsp_pts = {};
        if (m == MODE_IDLE) return;
        exp_tx.push_back(8'h55);
        case (m)
            MODE_LDCS: begin exp_tx.push_back({4'h8, cs}); rsp_pts.push_back(2); end
            MODE_STCS: begin exp_tx.push_back({4'hC, cs}); exp_tx.push_back(data); end
            MODE_LDS: begin
                exp_tx.push_back(8'h04); exp_tx.push_back(addr[7:0]); exp_tx.push_back(addr[15:8]);
                rsp_pts.push_back(4);
            end
            MODE_STS: begin
                exp_tx.push_back(8'h44); exp_tx.push_back(addr[7:0]); exp_tx.push_back(addr[15:8]);
                exp_tx.push_back(data);
                rsp_pts.push_back(4); rsp_pts.push_back(5);
            end
            default: begin
                exp_tx.push_back(8'hE0);
                for (int i = 0; i < 8; i++) exp_tx.push_back(key[8*i +: 8]);
            end
        endcase
    endtask

    // bad_echo/drop_echo: byte index; drop_rsp/bad_ack: response index; rst_after: bytes echoed before reset.
    task automatic do_txn(input updi_bridge_mode m, input logic [3:0] cs, input logic [15:0] addr,
                          input logic [7:0] data, input logic [63:0] key, input int stall,
                          input int bad_echo, input int drop_echo, input int drop_rsp,
                          input int bad_ack, input int rst_after);
        int sent, ri, lat, n;
        logic [7:0] obs, rd;
        logic exp_err, tmo_exp, tx_seen;
        build(m, cs, addr, data, key);
        exp_err = 1'b0; tmo_exp = 1'b0; rd = 8'h00;
        n = 0;
        while (!cmd_ready && n < 20) begin tick(); n++; end
        chk("cmd_ready", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_mode = m; cmd_cs_addr = cs; cmd_addr = addr; cmd_data = data; cmd_key = key;
        tick();
        cmd_valid = 1'b0;
        sent = 0; ri = 0;
        while (sent < exp_tx.size()) begin
            n = 0;
            while (!tx_valid && n < 20) begin tick(); n++; end
            chk("tx_valid", 64'(tx_valid), 64'(1));
            if (!tx_valid) break;
            for (int s = 0; s < stall; s++) begin
                if ($urandom_range(0, 1) == 1) begin rx_valid = 1'b1; rx_data = 8'($urandom); end
                tick();
                rx_valid = 1'b0;
                chk("tx_hold", 64'({tx_valid, tx_data}), 64'({1'b1, exp_tx[sent]}));
            end
            obs = tx_data;
            chk("tx_byte", 64'(obs), 64'(exp_tx[sent]));
            tx_ready = 1'b1;
            // An RX strobe in the accept cycle must not be taken as the echo.
            if ($urandom_range(0, 3) == 0) begin rx_valid = 1'b1; rx_data = ~obs; end
            tick();
            tx_ready = 1'b0; rx_valid = 1'b0;
            sent++;
            if (sent - 1 == drop_echo) begin exp_err = 1'b1; tmo_exp = 1'b1; break; end
            repeat ($urandom_range(0, 3)) tick();
            rx_valid = 1'b1; rx_frame_err = 1'b0;
            rx_data = (sent - 1 == bad_echo) ? (obs ^ 8'h01) : obs;
            tick();
            rx_valid = 1'b0;
            if (sent - 1 == bad_echo) begin exp_err = 1'b1; break; end
            if (sent == rst_after) begin
                chk("pre_rst_tx_valid", 64'(tx_valid), 64'(1));
                rst = 1'b1;
                tick();
                chk("rst_tx_valid", 64'(tx_valid), 64'(0));
                chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
                chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
                tick();
                chk("rst_hold_cmd_ready", 64'(cmd_ready), 64'(0));
                rst = 1'b0;
                tick();
                chk("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));
                chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
                chk("post_rst_tx_valid", 64'(tx_valid), 64'(0));
                return;
            end
            if (ri < rsp_pts.size() && rsp_pts[ri] == sent) begin
                if (ri == drop_rsp) begin exp_err = 1'b1; tmo_exp = 1'b1; break; end
                repeat ($urandom_range(0, 3)) tick();
                rx_valid = 1'b1;
                if (m == MODE_STS) begin
                    rx_data = (ri == bad_ack) ? 8'h00 : 8'h40;
                end else begin
                    rd = 8'($urandom);
                    rx_data = rd;
                end
                tick();
                rx_valid = 1'b0;
                if (ri == bad_ack) begin exp_err = 1'b1; break; end
                ri++;
            end
        end
        tx_seen = 1'b0; lat = 0;
        while (!rsp_valid && lat < 60) begin
            if (tx_valid) tx_seen = 1'b1;
            tick();
            lat++;
        end
        if (tx_valid) tx_seen = 1'b1;
        chk("rsp_valid", 64'(rsp_valid), 64'(1));
        chk("no_extra_tx", 64'(tx_seen), 64'(0));
        if (tmo_exp) chk("timeout_latency", 64'(lat), 64'(16));
        if (exp_err) rd = 8'h00;
        chk("rsp_error", 64'(rsp_error), 64'(exp_err));
        chk("rsp_data", 64'(rsp_data), 64'(rd));
        tick();
        chk("rsp_pulse", 64'(rsp_valid), 64'(0));
        chk("rsp_hold", 64'(rsp_data), 64'(rd));
    endtask

    initial begin
        logic [2:0] mv;
        int be;
        rst = 1'b1; cmd_valid = 1'b0; cmd_mode = MODE_IDLE; cmd_cs_addr = 4'h0; cmd_addr = 16'h0;
        cmd_data = 8'h00; cmd_key = 64'h0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        rx_frame_err = 1'b0;
        tick();
        chk("reset_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("reset_tx", 64'({tx_valid, tx_data}), 64'(0));
        chk("reset_rsp", 64'({rsp_valid, rsp_error, rsp_data}), 64'(0));
        tick();
        rst = 1'b0;
        tick();
        chk("reset_release_cmd_ready", 64'(cmd_ready), 64'(1));

        do_txn(MODE_LDCS, 4'h0, 16'h0, 8'h00, 64'h0, 0, -1, -1, -1, -1, -1);
        do_txn(MODE_STS, 4'h0, 16'h1000, 8'hA5, 64'h0, 3, -1, -1, -1, -1, -1);
        do_txn(MODE_KEY, 4'h0, 16'h0, 8'h00, 64'h4E564D50726F6720, 0, -1, -1, -1, -1, -1);
        do_txn(MODE_LDCS, 4'h0, 16'h0, 8'h00, 64'h0, 0, 1, -1, -1, -1, -1);
        do_txn(MODE_LDS, 4'h0, 16'h2345, 8'h00, 64'h0, 1, -1, -1, 0, -1, -1);
        do_txn(MODE_STS, 4'h0, 16'h1000, 8'h5A, 64'h0, 0, -1, -1, -1, 0, -1);
        do_txn(MODE_LDCS, 4'h3, 16'h0, 8'h00, 64'h0, 0, -1, 0, -1, -1, -1);
        do_txn(MODE_KEY, 4'h0, 16'h0, 8'h00, 64'h1122334455667788, 0, -1, -1, -1, -1, 4);
        do_txn(MODE_LDCS, 4'hB, 16'h0, 8'h00, 64'h0, 0, -1, -1, -1, -1, -1);
        do_txn(MODE_IDLE, 4'h0, 16'h0, 8'h00, 64'h0, 0, -1, -1, -1, -1, -1);
        do_txn(MODE_STCS, 4'h7, 16'h0, 8'h3C, 64'h0, 2, -1, -1, -1, -1, -1);
        do_txn(MODE_STS, 4'h0, 16'hBEEF, 8'h11, 64'h0, 0, -1, -1, -1, 1, -1);

        for (int t = 0; t < 40; t++) begin
            mv = 3'($urandom_range(0, 5));
            be = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 9)) : -1;
            do_txn(updi_bridge_mode'(mv), 4'($urandom), 16'($urandom), 8'($urandom),
                   {$urandom, $urandom}, int'($urandom_range(0, 2)), be, -1, -1, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
